// File: rtl/map_loader_pkg.sv
// map_loader_pkg
//   Shared constants, state encoding and helpers for the puzzle map loader.
//   Board geometry: 9x9 cells, cell k = i*9 + j, 4-bit value per cell.
//   Puzzle ROM word layout: {given, value[3:0]}.
package map_loader_pkg;

    localparam int CELLS      = 81;
    localparam int VALUE_W    = 4;
    localparam int PUZ_W      = 3;
    localparam int CELL_W     = 7;
    localparam int ROM_ADDR_W = 1 + PUZ_W + CELL_W;
    localparam int ROM_W      = 5;

    // ROM word field offsets
    localparam int GIVEN_BIT  = 4;
    localparam int VALUE_LSB  = 0;

    localparam logic [CELL_W-1:0] LAST_CELL = CELL_W'(CELLS - 1);

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_FETCH = 2'd1,
        LD_DRAIN = 2'd2,
        LD_DONE  = 2'd3
    } ld_state_t;

    // A legal sudoku cell value is 1..9; anything else flags a corrupt puzzle.
    function automatic logic is_bad_value(input logic [VALUE_W-1:0] v);
        return (v == '0) || (v > VALUE_W'(9));
    endfunction

endpackage

// File: rtl/map_loader.sv
// map_loader
//   Loads one puzzle from the synchronous puzzle ROM into the 324-bit
//   solution map and 81-bit visibility mask. The bank is chosen from
//   difficulty plus a free-running puzzle selector, both latched at start.
//   Cells are streamed into shadow registers and copied to the outputs in a
//   single edge, so downstream logic never sees a partially loaded puzzle.
//
// Ports
//   clk                  system clock
//   reset                asynchronous active-high reset
//   start                load request, sampled only in IDLE
//   difficulty           0 = easy bank, 1 = hard bank
//   rom_addr             {difficulty_l, puzzle_l, cell[6:0]}
//   rom_data             {given, value[3:0]}, valid one cycle after rom_addr
//   selected_map         cell k value at bits [4k+3:4k]
//   selected_visibility  bit k set when cell k is a given
//   busy                 high during FETCH and DRAIN
//   done                 one-cycle pulse when the outputs become valid
//   load_error           sticky until next start: a value was outside 1..9
module map_loader
    import map_loader_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       difficulty,
    output logic [ROM_ADDR_W-1:0]      rom_addr,
    input  logic [ROM_W-1:0]           rom_data,
    output logic [CELLS*VALUE_W-1:0]   selected_map,
    output logic [CELLS-1:0]           selected_visibility,
    output logic                       busy,
    output logic                       done,
    output logic                       load_error
);

    ld_state_t                  state_reg;
    logic [PUZ_W-1:0]           puzzle_sel_reg;
    logic                       difficulty_l_reg;
    logic [PUZ_W-1:0]           puzzle_l_reg;
    logic [CELL_W-1:0]          cell_reg;
    logic [CELLS*VALUE_W-1:0]   shadow_map_reg;
    logic [CELLS-1:0]           shadow_vis_reg;
    logic [CELLS*VALUE_W-1:0]   map_reg;
    logic [CELLS-1:0]           vis_reg;
    logic                       busy_reg;
    logic                       done_reg;
    logic                       error_reg;

    logic [CELLS*VALUE_W-1:0]   shadow_map_next;
    logic [CELLS-1:0]           shadow_vis_next;
    logic                       capture_en;
    logic [CELL_W-1:0]          capture_cell;
    logic [CELL_W+1:0]          slot_base;
    logic [VALUE_W-1:0]         rom_value;
    logic                       rom_given;

    assign rom_value = rom_data[VALUE_LSB +: VALUE_W];
    assign rom_given = rom_data[GIVEN_BIT];

    // The address is built straight from latched registers, so it holds the
    // last issued cell whenever the FSM is outside FETCH.
    assign rom_addr            = {difficulty_l_reg, puzzle_l_reg, cell_reg};
    assign selected_map        = map_reg;
    assign selected_visibility = vis_reg;
    assign busy                = busy_reg;
    assign done                = done_reg;
    assign load_error          = error_reg;

    // ROM data lags the address by one cycle: in FETCH the word on rom_data
    // belongs to cell-1 (nothing valid yet on the first FETCH cycle); in
    // DRAIN it belongs to the final cell, which cell_reg still holds.
    always_comb begin
        capture_en      = 1'b0;
        capture_cell    = cell_reg;
        shadow_map_next = shadow_map_reg;
        shadow_vis_next = shadow_vis_reg;
        if (state_reg == LD_FETCH) begin
            capture_en   = (cell_reg != '0);
            capture_cell = cell_reg - CELL_W'(1);
        end else if (state_reg == LD_DRAIN) begin
            capture_en   = 1'b1;
        end
        slot_base = {capture_cell, 2'b00};
        if (capture_en) begin
            shadow_map_next[slot_base +: VALUE_W] = rom_value;
            shadow_vis_next[capture_cell]         = rom_given;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= LD_IDLE;
            puzzle_sel_reg   <= '0;
            difficulty_l_reg <= 1'b0;
            puzzle_l_reg     <= '0;
            cell_reg         <= '0;
            shadow_map_reg   <= '0;
            shadow_vis_reg   <= '0;
            map_reg          <= '0;
            vis_reg          <= '0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            error_reg        <= 1'b0;
        end else begin
            puzzle_sel_reg <= puzzle_sel_reg + PUZ_W'(1);
            shadow_map_reg <= shadow_map_next;
            shadow_vis_reg <= shadow_vis_next;
            done_reg       <= 1'b0;

            if (capture_en && is_bad_value(rom_value)) begin
                error_reg <= 1'b1;
            end

            case (state_reg)
                LD_IDLE: begin
                    if (start) begin
                        difficulty_l_reg <= difficulty;
                        puzzle_l_reg     <= puzzle_sel_reg;
                        cell_reg         <= '0;
                        // Clearing here lets the consumer see |visibility == 0
                        // for the whole load.
                        map_reg          <= '0;
                        vis_reg          <= '0;
                        error_reg        <= 1'b0;
                        busy_reg         <= 1'b1;
                        state_reg        <= LD_FETCH;
                    end
                end
                LD_FETCH: begin
                    if (cell_reg == LAST_CELL) begin
                        state_reg <= LD_DRAIN;
                    end else begin
                        cell_reg  <= cell_reg + CELL_W'(1);
                    end
                end
                LD_DRAIN: begin
                    // Publish the whole image, including the final cell, at once.
                    map_reg   <= shadow_map_next;
                    vis_reg   <= shadow_vis_next;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= LD_DONE;
                end
                LD_DONE: begin
                    state_reg <= LD_IDLE;
                end
                default: begin
                    state_reg <= LD_IDLE;
                end
            endcase
        end
    end

endmodule
